boundary_scroll_ctrl: RTL
=========================

# boundary_scroll_ctrl

Sequencer that feeds and scrolls the 480-row circular boundary memory once per video frame. It buffers new 40-bit boundary rows from the software interface in a small FIFO and, on each frame-start pulse, issues `speed` scroll steps. Each step presents one row on the memory data input and toggles the memory's `shift` line. It sits between the CPU-facing register block and the boundary memory; the VGA reader uses the memory's read port and does not interact with this block.

## Interface
- `DATA_W`, 40, boundary row width (matches boundary memory).
- `FIFO_DEPTH`, 4, pending-row buffer depth (power of 2).
- `SPEED_W`, 3, width of the rows-per-frame field.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  single-cycle pulse at start of vertical blanking.
- `enable`  in  1  scrolling enabled; sampled only on `frame_start`.
- `speed`  in  SPEED_W  rows to scroll per frame; sampled on `frame_start`.
- `row_data`  in  DATA_W  new boundary row from software.
- `row_valid`  in  1  `row_data` valid.
- `row_ready`  out  1  FIFO can accept; a push occurs when `row_valid && row_ready`.
- `shift`  out  1  toggle line to boundary memory; one toggle per scrolled row.
- `mem_data`  out  DATA_W  row presented to the boundary memory write port.
- `busy`  out  1  scroll sequence in progress.
- `underrun`  out  1  one-cycle pulse when a step found the FIFO empty.
- `underrun_count`  out  16  saturating count of underruns.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- FSM states: IDLE, LOAD, SHIFT, HOLD.
- IDLE: when `frame_start && enable && speed != 0`, latch `speed` into `rows_left` and go to LOAD. Otherwise remain in IDLE.
- LOAD:
  - If the FIFO is not empty, pop the head into `mem_data` and `last_row`.
  - Else set `mem_data = last_row` (repeat the previous boundary), pulse `underrun`, and increment `underrun_count` (saturates at 16'hFFFF).
  - Go to SHIFT.
- SHIFT: invert `shift`, decrement `rows_left`, go to HOLD.
- HOLD: stays 2 cycles (counter). Then go to LOAD if `rows_left != 0`, else IDLE.
- Per row: exactly 4 cycles (LOAD, SHIFT, HOLD, HOLD). Maximum 7 rows = 28 cycles per frame.
- `mem_data` is stable from LOAD until the next LOAD. This covers the memory's toggle-detect cycle and its following write-enable cycle.
- `busy` is 1 in every state except IDLE.
- `frame_start` while `busy` is ignored; the current sequence runs to completion. A change in `enable` or `speed` mid-sequence has no effect until the next accepted `frame_start`.
- FIFO:
  - `row_ready = !full && !reset`.
  - Push and pop in the same cycle are both honoured; level is unchanged.
  - When full, `row_ready` is 0 even if a pop occurs that cycle (no bypass).
  - When empty, a same-cycle push is not visible to a LOAD pop; that step underruns.
- Pointers wrap modulo `FIFO_DEPTH`. Level is held in an extra bit so full and empty are distinct.

## Timing
- Reset values: state IDLE, `shift`=0, `mem_data`=0, `last_row`=0, FIFO empty, `fifo_level`=0, `row_ready`=0 while `reset`=1, `busy`=0, `underrun`=0, `underrun_count`=0.
- Reset asserted mid-sequence aborts at the next edge. `shift` returns to 0.
  - Boundary memory owns its own base pointers. Software must reset both blocks together or reload the 480 rows.
- `frame_start` at edge N: `busy`=1 from N+1. First pop/`mem_data` update at N+1, `shift` toggles at N+2. The last row's HOLD ends at N+4·speed, and `busy`=0 from N+4·speed+1.
- `row_ready` is combinational from the FIFO level. All other outputs are registered.

## Structure
- Package `boundary_pkg`:
  - `BOUNDARY_W` = 40.
  - `BOUNDARY_ROWS` = 480.
  - `ROW_CYCLES` = 4.
  - Enum `scroll_state_t` {IDLE, LOAD, SHIFT, HOLD}.
- Sub-module `row_fifo`: parameterised synchronous FIFO with push/pop/full/empty/level and a registered head output. The controller holds only the FSM, counters and `last_row`.

## Test plan
- Reset, push rows A=40'h1, B=40'h2, then pulse `frame_start` with speed=2, enable=1 -> `mem_data`=A, then B. `shift` toggles 0→1→0 at cycles 2 and 6 after the pulse. `busy` is high for 8 cycles. `fifo_level` returns to 0.
- FIFO empty, `last_row`=B, speed=3 -> three steps with `mem_data`=B. Three `underrun` pulses, `underrun_count`=3, `shift` toggles 3 times.
- Push 5 rows back-to-back with no scrolling -> 4 accepted, `row_ready`=0 on the 5th, `fifo_level`=4. One scroll step makes `row_ready` return to 1.
- Second `frame_start` 5 cycles into a speed=7 sequence -> ignored. Exactly 7 toggles, and `busy` falls 28 cycles after the first pulse.
- `reset` asserted at the SHIFT cycle of the 2nd row -> next cycle: IDLE, `shift`=0, `mem_data`=0, FIFO empty, `underrun_count`=0.
- `enable`=0 or speed=0 at `frame_start` -> no toggles, `busy` stays 0, FIFO contents unchanged.

Source files
------------

// File: rtl/boundary_pkg.sv
// Shared constants and state encoding for the boundary scroll sequencer.
package boundary_pkg;

  localparam int BOUNDARY_W    = 40;
  localparam int BOUNDARY_ROWS = 480;
  localparam int ROW_CYCLES    = 4;
  // LOAD and SHIFT take one cycle each; the rest of a row is spent in HOLD.
  localparam int HOLD_CYCLES   = ROW_CYCLES - 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    HOLD
  } scroll_state_t;

endpackage

// File: rtl/boundary_scroll_ctrl_row_fifo.sv
// Small synchronous FIFO for pending boundary rows.
// The storage is register-based and the head entry is always presented on head.
// An extra level bit keeps the full and empty states distinct.
// DEPTH must be a power of two so the pointers wrap naturally.
module row_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [W-1:0]  storage [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = storage[rd_ptr];

  // Row storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      storage[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        level <= level + 1'b1;
      end else if (pop_ok && !push_ok) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/boundary_scroll_ctrl.sv
// Boundary scroll sequencer.
// On each accepted frame start it feeds speed rows into the circular boundary memory.
// Each row takes four cycles: LOAD presents the row, SHIFT toggles shift,
// and HOLD keeps mem_data stable for two cycles while the memory detects the
// toggle and writes the row. Rows come from a small FIFO. When the FIFO is
// empty, the previous row is repeated and an underrun is flagged.
module boundary_scroll_ctrl
  import boundary_pkg::*;
#(
  parameter int DATA_W     = BOUNDARY_W,
  parameter int FIFO_DEPTH = 4,
  parameter int SPEED_W    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          enable,
  input  logic [SPEED_W-1:0]            speed,
  input  logic [DATA_W-1:0]             row_data,
  input  logic                          row_valid,
  output logic                          row_ready,
  output logic                          shift,
  output logic [DATA_W-1:0]             mem_data,
  output logic                          busy,
  output logic                          underrun,
  output logic [15:0]                   underrun_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  scroll_state_t        state;
  scroll_state_t        next_state;
  logic [SPEED_W-1:0]   rows_left;
  logic                 hold_cnt;
  logic                 hold_last;
  logic [DATA_W-1:0]    last_row;
  logic [DATA_W-1:0]    head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 accept;

  // Readiness comes straight from the FIFO level, so a full FIFO cannot accept a row even when a pop happens in the same cycle.
  assign row_ready = !fifo_full && !reset;
  assign push      = row_valid && row_ready;
  assign hold_last = (int'(hold_cnt) == HOLD_CYCLES - 1);

  row_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (row_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic, FIFO pop request and frame-start acceptance.
  // A frame start is ignored until the busy flag of the previous sequence has cleared.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        accept = frame_start && enable && (speed != '0) && !busy;
        if (accept) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        pop        = !fifo_empty;
        next_state = SHIFT;
      end
      SHIFT: begin
        next_state = HOLD;
      end
      HOLD: begin
        if (hold_last) begin
          next_state = (rows_left != '0) ? LOAD : IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: row counter, hold timer, memory-facing outputs and the underrun bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      rows_left      <= '0;
      hold_cnt       <= 1'b0;
      shift          <= 1'b0;
      mem_data       <= '0;
      last_row       <= '0;
      busy           <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      busy     <= (state != IDLE);
      underrun <= 1'b0;
      hold_cnt <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rows_left <= speed;
          end
        end
        LOAD: begin
          if (!fifo_empty) begin
            mem_data <= head;
            last_row <= head;
          end else begin
            mem_data <= last_row;
            underrun <= 1'b1;
            if (underrun_count != 16'hFFFF) begin
              underrun_count <= underrun_count + 16'd1;
            end
          end
        end
        SHIFT: begin
          shift     <= ~shift;
          rows_left <= rows_left - 1'b1;
        end
        HOLD: begin
          if (!hold_last) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
